cdc_handshake_tx: RTL and testbench

- Source (transmitter) end of a 4-phase req/ack handshake that carries a WIDTH-bit word into another clock domain.
- Accepts a word over a local valid/ready interface and holds it stable on tx_data. It raises tx_req, waits for the far side's tx_ack, drops tx_req, then waits for tx_ack to fall.
- tx_ack arrives asynchronously and is resynchronised internally through a SYNC_STAGES flop chain.
- Pairs with the receiving side, which synchronises tx_req with the team's standard sync block.

---
 rtl/cdc_handshake_tx.sv | 105 ++++++++++
 tb/tb_cdc_handshake_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | cdc_handshake_tx                                                         |
// | Transmit end of a 4-phase req/ack handshake carrying a WIDTH-bit word.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_req,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ack,
  output logic             busy,
  output logic             done
);

  generate
    if (SYNC_STAGES < 2) begin : g_sync_stages_check
      $error("cdc_handshake_tx: SYNC_STAGES must be 2 or more");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_req;
  logic [WIDTH-1:0]       r_data;
  logic                   r_done;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  logic                   w_accept;

  // tx_ack is only ever observed through this chain; bit 0 is the metastable flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync[0] <= tx_ack;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_ack_sync[i] <= r_ack_sync[i-1];
      end
    end
  end

  assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
  assign in_ready = (r_state == ST_IDLE) && !w_ack_s;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data  <= in_data;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Wait for the far side to drop ack before the word may be replaced.
          if (!w_ack_s) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_req  = r_req;
  assign tx_data = r_data;
  assign done    = r_done;
  assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_cdc_handshake_tx                                                      |
// | Directed vector bench for cdc_handshake_tx (SYNC_STAGES 2 and 3).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx_req, busy, done, tx_ack;
  logic [7:0] tx_data;

  logic       v3 = 1'b0;
  logic [7:0] d3 = 8'h00;
  logic       rdy3, req3, busy3, done3;
  logic [7:0] data3;

  // far-side selection: 0 loopback, 1 delayed model, 2 forced level
  int         mode = 0;
  logic       ack_model = 1'b0;
  logic       ack_force = 1'b0;
  int         dcnt = 0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign tx_ack = (mode == 0) ? tx_req : (mode == 1) ? ack_model : ack_force;

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .busy(busy), .done(done)
  );

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3),
    .in_ready(rdy3), .tx_req(req3), .tx_data(data3), .tx_ack(req3),
    .busy(busy3), .done(done3)
  );

  // Far side that raises ack 10 cycles after seeing req and drops it 5 cycles after req falls.
  always @(posedge clk) begin
    if (mode != 1) begin
      ack_model <= 1'b0;
      dcnt      <= 0;
    end else if (!ack_model) begin
      if (tx_req) begin
        if (dcnt == 9) begin ack_model <= 1'b1; dcnt <= 0; end
        else dcnt <= dcnt + 1;
      end else begin
        dcnt <= 0;
      end
    end else if (!tx_req) begin
      if (dcnt == 4) begin ack_model <= 1'b0; dcnt <= 0; end
      else dcnt <= dcnt + 1;
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       req;
    logic       bsy;
    logic       dn;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; mode = 0; ack_force = 1'b0;
    v3 = 1'b0; d3 = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic v, input logic [7:0] d, input logic rdy,
                         input logic req, input logic bsy, input logic dn, input logic [7:0] data);
    tbl[i].v = v; tbl[i].d = d; tbl[i].rdy = rdy; tbl[i].req = req;
    tbl[i].bsy = bsy; tbl[i].dn = dn; tbl[i].data = data;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rises, stable_bad, req_hi, drain_cnt, done_cnt, first_acc, second_acc;
    logic prev_req, prev_busy, seen;
    logic [7:0] prev_data;

    // Loopback, two transfers with ignored activity while busy.
    set_vec( 0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
    set_vec( 1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
    set_vec( 2, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
    set_vec( 3, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    set_vec( 4, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    set_vec( 5, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    set_vec( 6, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
    set_vec( 7, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    set_vec( 8, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    set_vec( 9, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    set_vec(10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    set_vec(11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
    set_vec(12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
    set_vec(13, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
    set_vec(14, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);
    set_vec(15, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);

    // Reset state
    #3;
    chk("reset_outputs", {28'd0, in_ready, tx_req, busy, done}, {28'd0, 4'b1000});
    chk("reset_tx_data", {24'd0, tx_data}, 32'h0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec[%0d]", i), {20'd0, in_ready, tx_req, busy, done, tx_data},
          {20'd0, tbl[i].rdy, tbl[i].req, tbl[i].bsy, tbl[i].dn, tbl[i].data});
      @(negedge clk);
    end

    // Held valid with incrementing data: accepts every 7 cycles.
    do_reset();
    rises = 0; stable_bad = 0; prev_req = 1'b0; prev_busy = 1'b0; prev_data = 8'h00;
    for (int k = 0; k < 21; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      @(posedge clk); #1;
      if (tx_req && !prev_req) begin
        chk($sformatf("incr_accept%0d", rises), {24'd0, tx_data}, 32'(rises * 7));
        rises++;
      end
      if (prev_busy && busy && tx_data !== prev_data) stable_bad++;
      prev_req = tx_req; prev_busy = busy; prev_data = tx_data;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("incr_accept_count", 32'(rises), 32'd3);
    chk("incr_data_stable", 32'(stable_bad), 32'd0);

    // Slow far side: ack rises 10 cycles late, falls 5 cycles late.
    do_reset();
    mode = 1;
    req_hi = 0; drain_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      in_valid = (k == 0);
      in_data  = 8'h96;
      @(posedge clk); #1;
      if (tx_req) req_hi++;
      if (busy && !tx_req) drain_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("slow_req_high_cycles", 32'(req_hi), 32'd13);
    chk("slow_drain_cycles", 32'(drain_cnt), 32'd8);
    chk("slow_done_pulses", 32'(done_cnt), 32'd1);
    chk("slow_tx_data", {24'd0, tx_data}, 32'h96);

    // Stale ack high before any request blocks acceptance.
    do_reset();
    mode = 2; ack_force = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    in_valid = 1'b1; in_data = 8'h77;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stale_blocked%0d", k), {30'd0, in_ready, busy}, 32'd0);
      @(negedge clk);
    end
    ack_force = 1'b0;
    @(posedge clk); #1;
    chk("stale_release_1", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("stale_release_2", {30'd0, in_ready, busy}, 32'b10);
    @(negedge clk);
    mode = 0;
    @(posedge clk); #1;
    chk("stale_accept", {23'd0, busy, tx_data}, {23'd0, 1'b1, 8'h77});
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("stale_transfer_done", {31'd0, seen}, 32'd1);

    // Asynchronous reset in the middle of REQ.
    do_reset();
    in_valid = 1'b1; in_data = 8'hC3;
    @(posedge clk); #1;
    chk("midreset_accept", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'hC3});
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_async", {22'd0, tx_req, busy, tx_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midreset_after%0d", k), {29'd0, in_ready, busy, tx_req}, 32'b100);
      @(negedge clk);
    end

    // SYNC_STAGES=3 loopback with held valid.
    do_reset();
    rises = 0; req_hi = 0; drain_cnt = 0; first_acc = -1; second_acc = -1;
    prev_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      v3 = 1'b1;
      d3 = 8'(k);
      @(posedge clk); #1;
      if (req3 && !prev_req) begin
        if (rises == 0) first_acc = k;
        if (rises == 1) begin
          second_acc = k;
          chk("ss3_second_word", {24'd0, data3}, 32'h09);
        end
        rises++;
      end
      if (k < 9 && req3) req_hi++;
      if (k < 9 && busy3 && !req3) drain_cnt++;
      if (k == 8) chk("ss3_done_pulse", {31'd0, done3}, 32'd1);
      prev_req = req3;
      @(negedge clk);
    end
    v3 = 1'b0;
    chk("ss3_req_high_cycles", 32'(req_hi), 32'd4);
    chk("ss3_req_low_cycles", 32'(drain_cnt), 32'd4);
    chk("ss3_accept_interval", 32'(second_acc - first_acc), 32'd9);
    chk("ss3_accept_count", 32'(rises), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
